// File: rtl/euler_accum_pkg.sv
// Shared widths, state encoding and saturation limits for the Euler accumulator.
package euler_accum_pkg;

    localparam int STATE_W = 16;
    localparam int PROD_W  = 32;
    localparam int CNT_W   = 3;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/euler_accum_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp to 16 bits.
// SHIFT=0 turns it into a plain clamp, which is how the accumulate path uses it.
module round_sat
    import euler_accum_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]    din,
    output logic signed [STATE_W-1:0] dout,
    output logic                      sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] RND = EXT_W'((64'd1 << SHIFT) >> 1);
    localparam logic signed [EXT_W-1:0] HI  = EXT_W'(SAT_MAX);
    localparam logic signed [EXT_W-1:0] LO  = EXT_W'(SAT_MIN);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    // Round, scale, then clamp to the signed 16-bit range.
    always_comb begin
        ext     = {din[IN_W-1], din};
        biased  = ext + RND;
        shifted = biased >>> SHIFT;
        dout    = shifted[STATE_W-1:0];
        sat     = 1'b0;
        if (shifted > HI) begin
            dout = STATE_W'(SAT_MAX);
            sat  = 1'b1;
        end else if (shifted < LO) begin
            dout = STATE_W'(SAT_MIN);
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/euler_accum.sv
// Euler-step accumulator: loads y0, adds N_TERMS scaled products, emits y.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for an initial state y0; only init is accepted
// ST_ACCUM  | accepting products, counting terms toward N_TERMS
// ST_OUTPUT | holding y until the consumer takes it; products back-pressured
module euler_accum
    import euler_accum_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int N_TERMS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_valid,
    input  logic signed [STATE_W-1:0] init_data,
    output logic                      init_ready,
    input  logic                      p_valid,
    input  logic signed [PROD_W-1:0]  p_data,
    output logic                      p_ready,
    output logic                      y_valid,
    output logic signed [STATE_W-1:0] y_data,
    input  logic                      y_ready,
    output logic                      sat
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic signed [STATE_W-1:0] acc;
    logic signed [STATE_W-1:0] term;
    logic signed [STATE_W-1:0] acc_next;
    logic signed [STATE_W:0]   sum_wide;
    logic                      term_sat;
    logic                      sum_sat;
    logic                      init_fire;
    logic                      p_fire;
    logic                      y_fire;

    round_sat #(
        .IN_W  (PROD_W),
        .SHIFT (FRAC_BITS)
    ) u_term (
        .din  (p_data),
        .dout (term),
        .sat  (term_sat)
    );

    round_sat #(
        .IN_W  (STATE_W + 1),
        .SHIFT (0)
    ) u_sum (
        .din  (sum_wide),
        .dout (acc_next),
        .sat  (sum_sat)
    );

    // Handshakes use the registered ready/valid, so no input reaches an output combinationally.
    always_comb begin
        sum_wide  = {acc[STATE_W-1], acc} + {term[STATE_W-1], term};
        init_fire = init_valid && init_ready;
        p_fire    = p_valid && p_ready;
        y_fire    = y_valid && y_ready;
    end

    // Sequencer with all handshake outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            acc        <= '0;
            y_data     <= '0;
            y_valid    <= 1'b0;
            sat        <= 1'b0;
            p_ready    <= 1'b0;
            init_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init_fire) begin
                        state      <= ST_ACCUM;
                        acc        <= init_data;
                        cnt        <= '0;
                        sat        <= 1'b0;
                        init_ready <= 1'b0;
                        p_ready    <= 1'b1;
                    end else begin
                        init_ready <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (p_fire) begin
                        acc <= acc_next;
                        if (term_sat || sum_sat) begin
                            sat <= 1'b1;
                        end
                        if (cnt == LAST) begin
                            state   <= ST_OUTPUT;
                            cnt     <= '0;
                            p_ready <= 1'b0;
                            y_valid <= 1'b1;
                            y_data  <= acc_next;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    // Accumulator is kept so the next step continues from y.
                    if (y_fire) begin
                        state   <= ST_ACCUM;
                        cnt     <= '0;
                        y_valid <= 1'b0;
                        p_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_euler_accum.sv
// Directed bench for euler_accum: one instance with N_TERMS=1, one with N_TERMS=3.
module tb_euler_accum;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        init_valid [2];
    logic [15:0] init_data  [2];
    logic        init_ready [2];
    logic        p_valid    [2];
    logic [31:0] p_data     [2];
    logic        p_ready    [2];
    logic        y_valid    [2];
    logic [15:0] y_data     [2];
    logic        y_ready    [2];
    logic        sat        [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    euler_accum #(.FRAC_BITS(8), .N_TERMS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .init_valid(init_valid[0]), .init_data(init_data[0]), .init_ready(init_ready[0]),
        .p_valid(p_valid[0]), .p_data(p_data[0]), .p_ready(p_ready[0]),
        .y_valid(y_valid[0]), .y_data(y_data[0]), .y_ready(y_ready[0]),
        .sat(sat[0])
    );

    euler_accum #(.FRAC_BITS(8), .N_TERMS(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .init_valid(init_valid[1]), .init_data(init_data[1]), .init_ready(init_ready[1]),
        .p_valid(p_valid[1]), .p_data(p_data[1]), .p_ready(p_ready[1]),
        .y_valid(y_valid[1]), .y_data(y_data[1]), .y_ready(y_ready[1]),
        .sat(sat[1])
    );

    typedef struct {
        int          d;
        logic [15:0] init;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [15:0] y;
        logic        s;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_init(input int d, input logic [15:0] v);
        int n = 0;
        init_data[d]  = v;
        init_valid[d] = 1'b1;
        while (init_ready[d] !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) timeout("init_ready");
        @(posedge clk);
        #1 init_valid[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_p(input int d, input logic [31:0] v);
        int n = 0;
        p_data[d]  = v;
        p_valid[d] = 1'b1;
        while (p_ready[d] !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) timeout("p_ready");
        @(posedge clk);
        #1 p_valid[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic take_y(input int d);
        int n = 0;
        y_ready[d] = 1'b1;
        while (y_valid[d] !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) timeout("y_valid");
        @(posedge clk);
        #1 y_ready[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input int d, input string nm);
        chk({nm, "_y_data"},     32'(y_data[d]),     32'h0);
        chk({nm, "_y_valid"},    32'(y_valid[d]),    32'h0);
        chk({nm, "_sat"},        32'(sat[d]),        32'h0);
        chk({nm, "_p_ready"},    32'(p_ready[d]),    32'h0);
        chk({nm, "_init_ready"}, 32'(init_ready[d]), 32'h0);
    endtask

    initial begin
        int          d;
        int          n;
        logic [31:0] pv;

        for (int i = 0; i < 2; i++) begin
            init_valid[i] = 1'b0;
            init_data[i]  = '0;
            p_valid[i]    = 1'b0;
            p_data[i]     = '0;
            y_ready[i]    = 1'b0;
        end

        //          d  init      p0            p1            p2            y         sat
        vecs[0]  = '{0, 16'h0100, 32'h00008000, 32'h0,        32'h0,        16'h0180, 1'b0};
        vecs[1]  = '{0, 16'h0000, 32'h00000080, 32'h0,        32'h0,        16'h0001, 1'b0};
        vecs[2]  = '{0, 16'h0000, 32'hFFFFFF80, 32'h0,        32'h0,        16'h0000, 1'b0};
        vecs[3]  = '{0, 16'h7F00, 32'h00010000, 32'h0,        32'h0,        16'h7FFF, 1'b1};
        vecs[4]  = '{0, 16'h0010, 32'h00000000, 32'h0,        32'h0,        16'h0010, 1'b0};
        vecs[5]  = '{0, 16'h8000, 32'hFFFFFF00, 32'h0,        32'h0,        16'h8000, 1'b1};
        vecs[6]  = '{0, 16'h0000, 32'h7FFFFFFF, 32'h0,        32'h0,        16'h7FFF, 1'b1};
        vecs[7]  = '{0, 16'h0000, 32'hFFFFFE7F, 32'h0,        32'h0,        16'hFFFE, 1'b0};
        vecs[8]  = '{1, 16'h0000, 32'h00000100, 32'h00000100, 32'h00000100, 16'h0003, 1'b0};
        vecs[9]  = '{1, 16'h0005, 32'h00000180, 32'hFFFFFF00, 32'h00000280, 16'h0009, 1'b0};
        vecs[10] = '{1, 16'h7FF0, 32'h00001000, 32'hFFFFF000, 32'h00000000, 16'h7FEF, 1'b1};

        // Reset state, checked asynchronously before any clock edge.
        #1 reset = 1'b1;
        #2;
        chk_all_zero(0, "rst1");
        chk_all_zero(1, "rst3");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("init_ready_after_rst", 32'(init_ready[0]), 32'h1);

        for (int i = 0; i < 11; i++) begin
            d = vecs[i].d;
            n = (d == 0) ? 1 : 3;
            pulse_reset();
            send_init(d, vecs[i].init);
            for (int k = 0; k < n; k++) begin
                pv = (k == 0) ? vecs[i].p0 : (k == 1) ? vecs[i].p1 : vecs[i].p2;
                send_p(d, pv);
                if (k < n - 1) begin
                    chk($sformatf("v%0d_early_y_valid", i), 32'(y_valid[d]), 32'h0);
                end else begin
                    chk($sformatf("v%0d_y_valid", i), 32'(y_valid[d]), 32'h1);
                    chk($sformatf("v%0d_p_ready", i), 32'(p_ready[d]), 32'h0);
                    chk($sformatf("v%0d_y_data", i),  32'(y_data[d]),  32'(vecs[i].y));
                    chk($sformatf("v%0d_sat", i),     32'(sat[d]),     32'(vecs[i].s));
                end
            end
            take_y(d);
            chk($sformatf("v%0d_y_valid_after", i), 32'(y_valid[d]), 32'h0);
            chk($sformatf("v%0d_p_ready_after", i), 32'(p_ready[d]), 32'h1);
        end

        // Stray y_ready in ACCUM, back-pressure with ignored products, then a retained second step.
        pulse_reset();
        send_init(1, 16'h0000);
        y_ready[1] = 1'b1;
        @(negedge clk);
        y_ready[1] = 1'b0;
        chk("stray_yr_p_ready", 32'(p_ready[1]), 32'h1);
        chk("stray_yr_y_valid", 32'(y_valid[1]), 32'h0);
        for (int k = 0; k < 3; k++) send_p(1, 32'h00000100);
        p_valid[1] = 1'b1;
        p_data[1]  = 32'h00000100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_y_valid", c), 32'(y_valid[1]), 32'h1);
            chk($sformatf("bp%0d_y_data", c),  32'(y_data[1]),  32'h3);
            chk($sformatf("bp%0d_p_ready", c), 32'(p_ready[1]), 32'h0);
        end
        p_valid[1] = 1'b0;
        take_y(1);
        chk("bp_y_valid_after", 32'(y_valid[1]), 32'h0);
        chk("bp_p_ready_after", 32'(p_ready[1]), 32'h1);
        for (int k = 0; k < 3; k++) send_p(1, 32'h00000100);
        chk("step2_y_valid", 32'(y_valid[1]), 32'h1);
        chk("step2_y_data",  32'(y_data[1]),  32'h6);
        take_y(1);

        // Reset in the middle of an accumulation that has already saturated.
        pulse_reset();
        send_init(1, 16'h7FFF);
        send_p(1, 32'h00000100);
        chk("mid_sat_set",   32'(sat[1]),     32'h1);
        chk("mid_y_valid",   32'(y_valid[1]), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk_all_zero(1, "mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_init_ready", 32'(init_ready[1]), 32'h1);
        send_init(1, 16'h0002);
        for (int k = 0; k < 3; k++) send_p(1, 32'h00000100);
        chk("mid_fresh_y_valid", 32'(y_valid[1]), 32'h1);
        chk("mid_fresh_y_data",  32'(y_data[1]),  32'h5);
        chk("mid_fresh_sat",     32'(sat[1]),     32'h0);
        take_y(1);

        // init and p both valid in IDLE: only init transfers.
        pulse_reset();
        init_data[0]  = 16'h0040;
        p_data[0]     = 32'h00010000;
        init_valid[0] = 1'b1;
        p_valid[0]    = 1'b1;
        @(posedge clk);
        #1;
        init_valid[0] = 1'b0;
        p_valid[0]    = 1'b0;
        @(negedge clk);
        chk("simul_p_ready", 32'(p_ready[0]), 32'h1);
        chk("simul_y_valid", 32'(y_valid[0]), 32'h0);
        send_p(0, 32'h00000000);
        chk("simul_y_valid_final", 32'(y_valid[0]), 32'h1);
        chk("simul_y_data",        32'(y_data[0]),  32'h0040);
        take_y(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
